// File: rtl/amdc_spi_adc_emulator_if.sv
// SPI-side bus of the ADC emulator: conversion strobe and serial clock in, two MISO lanes out.
interface amdc_spi_adc_emulator_if;
   logic cnv;
   logic sclk;
   logic miso_x;
   logic miso_y;

   modport master (output cnv, sclk, input miso_x, miso_y);
   modport slave  (input cnv, sclk, output miso_x, miso_y);
endinterface

// File: rtl/amdc_spi_adc_emulator.sv
// Emulates a dual-lane 18-bit SPI ADC: cnv frames a conversion, then 18 sclk falls shift out X/Y MSB first.
// Optional test-pattern ramp source is enabled with `define AMDC_ADC_EMU_PATTERN_EN.
module amdc_spi_adc_emulator #(
   parameter logic [7:0] MIN_CNV_CYCLES = 8'd60
) (
   input  logic                          clk,
   input  logic                          rst,
   amdc_spi_adc_emulator_if.slave        spi,
   input  logic [17:0]                   data_x,
   input  logic [17:0]                   data_y,
   input  logic                          pattern_sel,
   input  logic                          clr_status,
   output logic                          busy,
   output logic                          frame_done,
   output logic [2:0]                    status
);

   typedef enum logic [1:0] {IDLE, CONV, SHIFT} state_t;

   state_t      state;
   logic [2:0]  cnv_sync, sclk_sync;
   logic [17:0] sr_x, sr_y;
   logic [17:0] load_x, load_y;
   logic [7:0]  cnv_cnt;
   logic [4:0]  bit_cnt;
   logic        miso_x_q, miso_y_q;
   logic [2:0]  st_set;
   logic        cnv_rise, cnv_fall, sclk_fall;

   // Stage [1] is the second synchronizer flop, stage [2] the edge-detect copy.
   assign cnv_rise  =  cnv_sync[1] & ~cnv_sync[2];
   assign cnv_fall  = ~cnv_sync[1] &  cnv_sync[2];
   assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];

   assign busy       = (state != IDLE);
   assign spi.miso_x = miso_x_q;
   assign spi.miso_y = miso_y_q;

`ifdef AMDC_ADC_EMU_PATTERN_EN
   logic [17:0] ramp;

   assign load_x = pattern_sel ? ramp  : data_x;
   assign load_y = pattern_sel ? ~ramp : data_y;

   always_ff @(posedge clk) begin
      if (rst)
         ramp <= '0;
      else if ((state == IDLE || state == SHIFT) && cnv_rise)
         ramp <= ramp + 18'd1;
   end
`else
   logic unused_pattern_sel;

   assign unused_pattern_sel = pattern_sel;
   assign load_x = data_x;
   assign load_y = data_y;
`endif

   always_comb begin
      st_set    = '0;
      st_set[0] = (state == CONV) && cnv_fall && (cnv_cnt < MIN_CNV_CYCLES);
      st_set[1] = (state != SHIFT) && sclk_fall;
      st_set[2] = (state == SHIFT) && cnv_rise;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnv_sync  <= '0;
         sclk_sync <= '0;
         status    <= '0;
      end else begin
         cnv_sync  <= {cnv_sync[1:0], spi.cnv};
         sclk_sync <= {sclk_sync[1:0], spi.sclk};
         // A flag raised in the same cycle as a clear survives.
         status    <= (clr_status ? 3'b000 : status) | st_set;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sr_x       <= '0;
         sr_y       <= '0;
         cnv_cnt    <= '0;
         bit_cnt    <= '0;
         miso_x_q   <= 1'b0;
         miso_y_q   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               miso_x_q <= 1'b0;
               miso_y_q <= 1'b0;
               if (cnv_rise) begin
                  sr_x    <= load_x;
                  sr_y    <= load_y;
                  cnv_cnt <= '0;
                  state   <= CONV;
               end
            end
            CONV: begin
               if (cnv_cnt != 8'd255)
                  cnv_cnt <= cnv_cnt + 8'd1;
               if (cnv_fall) begin
                  miso_x_q <= sr_x[17];
                  miso_y_q <= sr_y[17];
                  bit_cnt  <= '0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnv_rise) begin
                  // Abort: restart the conversion with fresh data, no frame_done.
                  sr_x     <= load_x;
                  sr_y     <= load_y;
                  cnv_cnt  <= '0;
                  miso_x_q <= 1'b0;
                  miso_y_q <= 1'b0;
                  state    <= CONV;
               end else if (sclk_fall) begin
                  sr_x    <= {sr_x[16:0], 1'b0};
                  sr_y    <= {sr_y[16:0], 1'b0};
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd17) begin
                     frame_done <= 1'b1;
                     miso_x_q   <= 1'b0;
                     miso_y_q   <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     miso_x_q <= sr_x[16];
                     miso_y_q <= sr_y[16];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_amdc_spi_adc_emulator.sv
// Directed bench for the SPI ADC emulator: vector table of full frames plus hand-written corner sequences.
module tb_amdc_spi_adc_emulator;

   logic        clk = 1'b0;
   logic        rst;
   logic [17:0] data_x, data_y;
   logic        pattern_sel, clr_status;
   logic        busy, frame_done;
   logic [2:0]  status;

   int checks   = 0;
   int failures = 0;
   int fd_cnt   = 0;

   amdc_spi_adc_emulator_if spi ();

   amdc_spi_adc_emulator #(.MIN_CNV_CYCLES(8'd60)) dut (
      .clk         (clk),
      .rst         (rst),
      .spi         (spi),
      .data_x      (data_x),
      .data_y      (data_y),
      .pattern_sel (pattern_sel),
      .clr_status  (clr_status),
      .busy        (busy),
      .frame_done  (frame_done),
      .status      (status)
   );

   always #5 clk = ~clk;

   // Counts cycles with frame_done high, so a stretched pulse shows up as an extra count.
   always @(negedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

   typedef struct {
      int          cnv_w;
      logic [17:0] dx;
      logic [17:0] dy;
      logic [2:0]  exp_st;
      bit          clr;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cnv_pulse(input int w);
      @(negedge clk);
      spi.cnv = 1'b1;
      idle(w);
      spi.cnv = 1'b0;
      idle(11);
   endtask

   task automatic shift_bits(input int n, output logic [17:0] cx, output logic [17:0] cy);
      cx = '0;
      cy = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cx = {cx[16:0], spi.miso_x};
         cy = {cy[16:0], spi.miso_y};
         spi.sclk = 1'b1;
         idle(11);
         spi.sclk = 1'b0;
         idle(10);
      end
   endtask

   task automatic run_frame(input int w, input logic [17:0] dx, input logic [17:0] dy,
                            output logic [17:0] cx, output logic [17:0] cy);
      data_x = dx;
      data_y = dy;
      cnv_pulse(w);
      shift_bits(18, cx, cy);
      idle(8);
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] cx, cy;
      int          fd0;

      vecs[0] = '{70,  18'h2A5C3, 18'h15A3C, 3'b000, 1'b0};
      vecs[1] = '{20,  18'h2A5C3, 18'h15A3C, 3'b001, 1'b1};
      vecs[2] = '{70,  18'h3FFFF, 18'h00000, 3'b000, 1'b0};
      vecs[3] = '{100, 18'h00001, 18'h20000, 3'b000, 1'b0};

      rst = 1'b1;
      spi.cnv = 1'b0;
      spi.sclk = 1'b0;
      data_x = '0;
      data_y = '0;
      pattern_sel = 1'b0;
      clr_status = 1'b0;
      idle(4);
      chk("reset_busy",   busy,       1'b0);
      chk("reset_miso_x", spi.miso_x, 1'b0);
      chk("reset_miso_y", spi.miso_y, 1'b0);
      chk("reset_status", status,     3'b000);
      chk("reset_fd",     frame_done, 1'b0);
      rst = 1'b0;
      idle(4);

      for (int v = 0; v < 4; v++) begin
         fd0 = fd_cnt;
         run_frame(vecs[v].cnv_w, vecs[v].dx, vecs[v].dy, cx, cy);
         chk($sformatf("v%0d_x", v),      cx,           vecs[v].dx);
         chk($sformatf("v%0d_y", v),      cy,           vecs[v].dy);
         chk($sformatf("v%0d_fd", v),     fd_cnt - fd0, 1);
         chk($sformatf("v%0d_status", v), status,       vecs[v].exp_st);
         chk($sformatf("v%0d_busy", v),   busy,         1'b0);
         if (vecs[v].clr) begin
            @(negedge clk);
            clr_status = 1'b1;
            @(negedge clk);
            clr_status = 1'b0;
            idle(2);
            chk($sformatf("v%0d_clr", v), status, 3'b000);
         end
      end

      // sclk pulses with no frame open
      fd0 = fd_cnt;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         spi.sclk = 1'b1;
         idle(5);
         spi.sclk = 1'b0;
         idle(5);
      end
      idle(5);
      chk("idle_sclk_status", status,       3'b010);
      chk("idle_sclk_miso",   spi.miso_x,   1'b0);
      chk("idle_sclk_busy",   busy,         1'b0);
      chk("idle_sclk_fd",     fd_cnt - fd0, 0);

      // reset mid-frame clears the sticky sclk_err as well
      data_x = 18'h1F0F0;
      data_y = 18'h0A0A5;
      cnv_pulse(70);
      shift_bits(5, cx, cy);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_busy",   busy,       1'b0);
      chk("rst_miso_x", spi.miso_x, 1'b0);
      chk("rst_miso_y", spi.miso_y, 1'b0);
      chk("rst_status", status,     3'b000);
      rst = 1'b0;
      idle(4);
      fd0 = fd_cnt;
      run_frame(70, 18'h1F0F0, 18'h0A0A5, cx, cy);
      chk("post_rst_x",  cx,           18'h1F0F0);
      chk("post_rst_y",  cy,           18'h0A0A5);
      chk("post_rst_fd", fd_cnt - fd0, 1);

      // cnv rise after 9 falls aborts and restarts with new data
      fd0 = fd_cnt;
      data_x = 18'h12345;
      data_y = 18'h2AAAA;
      cnv_pulse(70);
      shift_bits(9, cx, cy);
      chk("abort_partial_x", cx[8:0], 9'h091);
      data_x = 18'h0BEEF;
      data_y = 18'h31337;
      cnv_pulse(70);
      chk("abort_status", status,       3'b100);
      chk("abort_busy",   busy,         1'b1);
      chk("abort_fd",     fd_cnt - fd0, 0);
      shift_bits(18, cx, cy);
      idle(8);
      chk("abort_x",      cx,           18'h0BEEF);
      chk("abort_y",      cy,           18'h31337);
      chk("abort_fd_end", fd_cnt - fd0, 1);

      pulse_rst();
      idle(4);
      pattern_sel = 1'b1;
`ifdef AMDC_ADC_EMU_PATTERN_EN
      for (int f = 0; f < 3; f++) begin
         logic [17:0] rx, ry;
         rx = f[17:0];
         ry = ~rx;
         run_frame(70, 18'h2A5C3, 18'h15A3C, cx, cy);
         chk($sformatf("ramp%0d_x", f), cx, rx);
         chk($sformatf("ramp%0d_y", f), cy, ry);
      end
`else
      run_frame(70, 18'h2A5C3, 18'h15A3C, cx, cy);
      chk("patsel_ignored_x", cx, 18'h2A5C3);
      chk("patsel_ignored_y", cy, 18'h15A3C);
`endif
      pattern_sel = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/amdc_spi_adc_emulator.md
AMDC_SPI_ADC_EMULATOR -- requirements
Module: amdc_spi_adc_emulator

Interface
REQ-001 SHALL have parameter MIN_CNV_CYCLES, default 8'd60, the minimum legal cnv-high width in clk cycles.
REQ-002 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port cnv, input, 1, conversion strobe from the SPI master, asynchronous to clk.
REQ-005 SHALL have port sclk, input, 1, serial clock from the master, idle low, asynchronous to clk.
REQ-006 SHALL have ports data_x and data_y, input, 18 each, sample words to transmit.
REQ-007 SHALL have port pattern_sel, input, 1, selects the test-pattern source (REQ-026).
REQ-008 SHALL have port clr_status, input, 1, clears the sticky flags.
REQ-009 SHALL have ports miso_x and miso_y, output, 1 each, serial data, MSB first.
REQ-010 SHALL have port busy, output, 1, high in CONV or SHIFT.
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse after the 18th bit.
REQ-012 SHALL have port status, output, 3, sticky flags: [0] cnv_short, [1] sclk_err, [2] frame_abort.

Function
REQ-013 SHALL synchronize cnv and sclk through two flops each, then detect edges from a third registered copy.
- Detected edge: sync stage 2 differs from stage 3.
- All outputs respond one cycle after detection, within 4 clk of the raw edge.
REQ-014 SHALL implement states IDLE, CONV and SHIFT.
REQ-015 IDLE, on cnv rise:
- load data_x/data_y into 18-bit shift registers;
- clear the cnv-width counter;
- go to CONV.
REQ-016 CONV:
- increment the cnv-width counter each cycle, saturating at 255;
- on cnv fall, if count < MIN_CNV_CYCLES, set cnv_short;
- on cnv fall, drive miso_x/miso_y with bit 17 and go to SHIFT.
REQ-017 SHIFT, on each sclk fall:
- shift both registers left by one;
- present the next bit on miso;
- increment a 5-bit bit counter.
REQ-018 SHALL ignore sclk rises in every state; the master samples on rises, so bits are stable across each rise.
REQ-019 On the 18th sclk fall in SHIFT:
- pulse frame_done for one cycle;
- drive miso low;
- go to IDLE.
REQ-020 An sclk fall in IDLE or CONV SHALL set sclk_err and change no data or state.
REQ-021 A cnv rise in SHIFT SHALL set frame_abort, reload the data and reenter CONV; frame_done SHALL NOT pulse.
REQ-022 miso_x and miso_y SHALL be low in IDLE and CONV.
REQ-023 clr_status SHALL clear all status bits; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-024 busy SHALL be combinationally equal to (state != IDLE).

Reset
REQ-025 rst high at any clock edge SHALL force, regardless of any frame in progress:
- state IDLE;
- miso_x, miso_y, busy, frame_done = 0;
- status = 3'b000;
- shift registers, bit counter, cnv-width counter and synchronizer flops = 0.

Configuration
REQ-026 Macro AMDC_ADC_EMU_PATTERN_EN:
- When defined, an 18-bit ramp register SHALL reset to 0 and increment on every cnv-rise load.
- When defined and pattern_sel is high at load, the value loaded SHALL be ramp into X and ~ramp into Y, instead of data_x/data_y.
- When undefined, the ramp SHALL be absent and pattern_sel ignored; the port remains.

Verification
REQ-027 cnv high 70 cycles, data_x=18'h2A5C3, data_y=18'h15A3C, 18 sclk periods of 22 clk -> master-side capture 18'h2A5C3/18'h15A3C, frame_done one pulse, status=0.
REQ-028 cnv high 20 cycles, then a normal frame -> status[0]=1, data still correct; clr_status pulse -> status=0.
REQ-029 3 sclk pulses while IDLE -> status[1]=1, miso low, busy low, no frame_done.
REQ-030 cnv rise after 9 falls of a frame -> status[2]=1, no frame_done; the next full frame returns the newly loaded data_x.
REQ-031 rst asserted after 5 falls -> busy=0, miso=0, status=0 next cycle; the following frame is correct.
REQ-032 With AMDC_ADC_EMU_PATTERN_EN defined and pattern_sel=1, three frames -> X reads 0, 1, 2 and Y reads 18'h3FFFF, 18'h3FFFE, 18'h3FFFD.
